// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and constants for the MIPS datapath pipeline
//             registers. Defines the decode control-flag bundle so a bubble
//             is a single zero assignment.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_ALU_SEL_W  = 4;
   localparam int DEF_CNT_W      = 16;

   // Register specifier of the hard-wired zero register.
   localparam int REG_ZERO = 0;

   // The seven single-bit decode flags. The ALU selection code travels
   // alongside in its own register because its width is parametrised.
   typedef struct packed {
      logic reg_dest;
      logic branch;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic alu_src;
      logic reg_write;
   } ctrl_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/idex_stage_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Purpose  : Pure combinational load-use compare. Flags when the load in EX
//             writes a register that the instruction in decode reads.
//  Ports    : ex_valid, ex_mem_read, ex_rt  - state of the instruction in EX
//             id_valid, id_rs, id_rt       - source fields of decode
//             hazard                       - load-use dependency present
//  Revision : 1.0  initial release
// ============================================================================
module load_use_detect
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   output logic                  hazard
);

   // A load into the zero register writes nothing, so it never stalls.
   logic ex_rt_nonzero;
   logic src_match;

   assign ex_rt_nonzero = (ex_rt != REG_ADDR_W'(REG_ZERO));
   assign src_match     = (ex_rt == id_rs) | (ex_rt == id_rt);
   assign hazard        = ex_valid & ex_mem_read & id_valid & ex_rt_nonzero & src_match;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/idex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : idex_stage_reg
//  Purpose  : ID/EX pipeline register with valid bit, downstream hold, branch
//             flush, load-use hazard detection with bubble insertion and a
//             saturating bubble counter.
//  Ports    : clk, rst (sync, active high)
//             in_valid, control flags, alu_sel_in, pc/rd1/rd2/sext, rs/rt/rd
//             hold_in (freeze), flush_in (squash)
//             registered copies *_out, out_valid
//             hazard_stall_out - combinational hold request to PC and IF/ID
//             bubble_count     - saturating count of inserted bubbles
//  Revision : 1.0  initial release
// ============================================================================
module idex_stage_reg
   import mips_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int ALU_SEL_W  = DEF_ALU_SEL_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  reg_dest_in,
   input  logic                  branch_in,
   input  logic                  mem_read_in,
   input  logic                  mem_to_reg_in,
   input  logic                  mem_write_in,
   input  logic                  alu_src_in,
   input  logic                  reg_write_in,
   input  logic [ALU_SEL_W-1:0]  alu_sel_in,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [DATA_W-1:0]     rd1_in,
   input  logic [DATA_W-1:0]     rd2_in,
   input  logic [DATA_W-1:0]     sext_in,
   input  logic [REG_ADDR_W-1:0] rs_in,
   input  logic [REG_ADDR_W-1:0] rt_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  hold_in,
   input  logic                  flush_in,
   output logic                  out_valid,
   output logic                  reg_dest_out,
   output logic                  branch_out,
   output logic                  mem_read_out,
   output logic                  mem_to_reg_out,
   output logic                  mem_write_out,
   output logic                  alu_src_out,
   output logic                  reg_write_out,
   output logic [ALU_SEL_W-1:0]  alu_sel_out,
   output logic [DATA_W-1:0]     pc_out,
   output logic [DATA_W-1:0]     rd1_out,
   output logic [DATA_W-1:0]     rd2_out,
   output logic [DATA_W-1:0]     sext_out,
   output logic [REG_ADDR_W-1:0] rs_out,
   output logic [REG_ADDR_W-1:0] rt_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  hazard_stall_out,
   output logic [CNT_W-1:0]      bubble_count
);

   ctrl_t                 ctrl_q;
   ctrl_t                 ctrl_in;
   logic                  valid_q;
   logic [ALU_SEL_W-1:0]  alu_sel_q;
   logic [DATA_W-1:0]     pc_q;
   logic [DATA_W-1:0]     rd1_q;
   logic [DATA_W-1:0]     rd2_q;
   logic [DATA_W-1:0]     sext_q;
   logic [REG_ADDR_W-1:0] rs_q;
   logic [REG_ADDR_W-1:0] rt_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  hazard;
   logic                  insert_bubble;
   logic                  cnt_sat;

   assign ctrl_in = '{reg_dest:   reg_dest_in,
                      branch:     branch_in,
                      mem_read:   mem_read_in,
                      mem_to_reg: mem_to_reg_in,
                      mem_write:  mem_write_in,
                      alu_src:    alu_src_in,
                      reg_write:  reg_write_in};

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rt       (rt_q),
      .id_valid    (in_valid),
      .id_rs       (rs_in),
      .id_rt       (rt_in),
      .hazard      (hazard)
   );

   // A flush already squashes the dependent pair, so no stall is needed.
   // The stall is deliberately not masked by hold: upstream freezes anyway.
   assign hazard_stall_out = hazard & ~flush_in & ~rst;

   // Flush beats hold; a hazard bubble only enters when not held.
   assign insert_bubble = flush_in | (~hold_in & hazard);
   assign cnt_sat       = (cnt_q == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         alu_sel_q <= '0;
         pc_q      <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         sext_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
      end else if (insert_bubble) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         alu_sel_q <= '0;
         pc_q      <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         sext_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         if (!cnt_sat) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (!hold_in) begin
         valid_q   <= in_valid;
         // An invalid slot carries no control so it cannot write state.
         ctrl_q    <= in_valid ? ctrl_in : '0;
         alu_sel_q <= in_valid ? alu_sel_in : '0;
         pc_q      <= pc_in;
         rd1_q     <= rd1_in;
         rd2_q     <= rd2_in;
         sext_q    <= sext_in;
         rs_q      <= rs_in;
         rt_q      <= rt_in;
         rd_q      <= rd_in;
      end
   end

   assign out_valid      = valid_q;
   assign reg_dest_out   = ctrl_q.reg_dest;
   assign branch_out     = ctrl_q.branch;
   assign mem_read_out   = ctrl_q.mem_read;
   assign mem_to_reg_out = ctrl_q.mem_to_reg;
   assign mem_write_out  = ctrl_q.mem_write;
   assign alu_src_out    = ctrl_q.alu_src;
   assign reg_write_out  = ctrl_q.reg_write;
   assign alu_sel_out    = alu_sel_q;
   assign pc_out         = pc_q;
   assign rd1_out        = rd1_q;
   assign rd2_out        = rd2_q;
   assign sext_out       = sext_q;
   assign rs_out         = rs_q;
   assign rt_out         = rt_q;
   assign rd_out         = rd_q;
   assign bubble_count   = cnt_q;

endmodule : idex_stage_reg
`default_nettype wire
